multi_mode_rotate_reg: RTL and testbench
========================================

Name: multi_mode_rotate_reg

Overview:
- Parametrised successor to the team's single-mode rotate registers: a DW-bit register that loads data, holds it, or rotates/shifts it left or right by a variable step amount.
- Two operating styles: single-step operation under `en`, and an autonomous burst (`start`/`busy`/`done`) that repeats one operation a programmed number of times.
- Used as a datapath primitive for scramblers, barrel-style alignment and serialisers.

Parameters:
DW, 8, register width (>=2)
AW, 3, width of step-amount input; must satisfy 2**AW >= DW
CW, 4, width of burst-count input

Ports:
clk  input  1  rising-edge clock
async_rst_n  input  1  asynchronous active-low reset
load  input  1  parallel load of data (highest priority)
data  input  DW  parallel load value
en  input  1  perform one operation this cycle (IDLE only)
mode  input  3  0 hold, 1 ROR, 2 ROL, 3 SHR logical, 4 SHL, 5 SAR arithmetic, 6/7 hold
amt  input  AW  step amount per operation
ser_in  input  1  fill bit for modes 3/4
start  input  1  begin burst (IDLE only)
cnt  input  CW  number of burst operations
q  output  DW  register contents
ser_out  output  1  combinational: q[0] when mode is 1/3/5, else q[DW-1]
busy  output  1  burst in progress
done  output  1  one-cycle pulse on burst completion

Behaviour:
- Reset: asynchronous on async_rst_n low, independent of clk.
  - q=0, busy=0, done=0, state IDLE, internal count=0, latched mode/amt=0.
  - Release is synchronous to the next edge with no glitch; priority logic resumes at the first edge after release.
- Step function f(q, mode, amt), with s = amt mod DW:
  - ROR/ROL: rotate by s; s=0 means no change.
  - SHR/SHL: shift by amt; vacated bits take ser_in; amt>=DW gives all bits = ser_in.
  - SAR: shift right by amt with sign fill; amt>=DW gives all bits = q[DW-1].
  - amt=0 returns q unchanged for every mode.
- IDLE, per edge, in priority order:
  - load: q<=data.
  - else start with cnt!=0: latch mode/amt, remaining<=cnt, go RUN, busy<=1; q unchanged this edge.
  - else start with cnt==0: done<=1 next cycle, q unchanged, no RUN.
  - else en: q<=f(q,mode,amt).
  - else hold.
- RUN, per edge:
  - load: q<=data, abort to IDLE, busy<=0, no done pulse.
  - else q<=f(q, latched mode, latched amt) and remaining--. When remaining was 1, go IDLE, busy<=0, done<=1.
  - en, start, and live mode/amt are ignored in RUN.
- Timing:
  - Burst of N started at edge E0 performs steps at E1..EN.
  - busy is high after E0 through EN; done is high for the cycle after EN, then cleared at EN+1.
  - Step result is visible in q right after its edge (latency 1).
- done is cleared at every edge unless set by a completion; it is never set by an abort.
- async_rst_n asserted mid-burst returns everything to the reset values immediately; there is no done pulse.

Decomposition:
- Shared package holds the mode encodings (MODE_HOLD, MODE_ROR, MODE_ROL, MODE_SHR, MODE_SHL, MODE_SAR) and the FSM state enum (ST_IDLE, ST_RUN).
- One combinational sub-module, rotate_shift_unit, implements f(q, mode, amt, ser_in), parameterised by DW/AW.
- The top holds the FSM, counter, latches and q register.

Test Plan (DW=8, AW=3, CW=4):
- Async reset: load 8'hB4, then drop async_rst_n at 3 ns after an edge -> q=8'h00 and busy=0 immediately, before the next edge.
- Single step: load 8'hB4; en mode=1 amt=1 -> q=8'h5A; en mode=2 amt=3 -> q=8'hD2; en mode=0 -> q stays 8'hD2; mode=1 amt=0 -> q=8'hD2.
- Shifts: load 8'h81, mode=5 amt=2 -> 8'hE0; load 8'h0F, mode=3 amt=4 ser_in=1 -> 8'hF0; load 8'h0F, mode=4 amt=7 ser_in=0 -> 8'h80. ser_out is 0 in modes 3/5 (q=8'hE0 / 8'hF0) and 1 in mode 4 (q=8'h80).
- Burst: load 8'h01; start cnt=4 mode=1 amt=2 -> busy high 4 cycles, q=8'h40,8'h10,8'h04,8'h01, then done=1 for exactly one cycle with busy=0. Changing mode/amt or pulsing en/start during RUN has no effect.
- Abort: burst cnt=8 from 8'h01, assert load data=8'h3C on the 3rd RUN cycle -> q=8'h3C, busy=0, done never asserts.
- Zero-count start: start cnt=0 -> busy stays 0, q unchanged, done=1 for one cycle. Simultaneous load+start -> load wins, q=data, no burst.

Source files
------------

// File: rtl/multi_mode_rotate_reg_pkg.sv
// Shared encodings for the multi-mode rotate register: step modes, FSM states
// and the serial-output tap selection.
package multi_mode_rotate_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_ROR  = 3'd1;
  localparam logic [2:0] MODE_ROL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_SHL  = 3'd4;
  localparam logic [2:0] MODE_SAR  = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Right-moving modes emit the LSB; everything else emits the MSB.
  function automatic logic ser_from_lsb(logic [2:0] mode);
    return (mode == MODE_ROR) || (mode == MODE_SHR) || (mode == MODE_SAR);
  endfunction

endpackage

// File: rtl/multi_mode_rotate_reg_if.sv
// Control/data bundle of the multi-mode rotate register; master drives the
// controls, slave is the register itself.
interface multi_mode_rotate_reg_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3,
  parameter int unsigned CW = 4
);
  logic          load;
  logic [DW-1:0] data;
  logic          en;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic          ser_in;
  logic          start;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q;
  logic          ser_out;
  logic          busy;
  logic          done;

  modport master (
    output load, data, en, mode, amt, ser_in, start, cnt,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  load, data, en, mode, amt, ser_in, start, cnt,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/rotate_shift_unit.sv
// Combinational step function: rotate/shift q by amt according to mode, with
// ser_in (or the sign bit) filling vacated positions.
module rotate_shift_unit
  import multi_mode_rotate_reg_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic [DW-1:0] q,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          ser_in,
  output logic [DW-1:0] res
);

  localparam logic [DW-1:0] Ones = '1;

  int unsigned   amt_u;
  int unsigned   rot_s;
  logic [DW-1:0] fill_r;
  logic [DW-1:0] fill_l;
  logic [DW-1:0] sign_r;

  always_comb begin
    amt_u = 32'(amt);
    rot_s = amt_u % DW;
    // Shifting by >= DW yields zero, so these masks cover amt >= DW naturally.
    fill_r = ~(Ones >> amt_u) & {DW{ser_in}};
    fill_l = ~(Ones << amt_u) & {DW{ser_in}};
    sign_r = ~(Ones >> amt_u) & {DW{q[DW-1]}};

    res = q;
    case (mode)
      MODE_ROR: res = (q >> rot_s) | (q << (DW - rot_s));
      MODE_ROL: res = (q << rot_s) | (q >> (DW - rot_s));
      MODE_SHR: res = (q >> amt_u) | fill_r;
      MODE_SHL: res = (q << amt_u) | fill_l;
      MODE_SAR: res = (q >> amt_u) | sign_r;
      default:  res = q;
    endcase
  end

endmodule

// File: rtl/multi_mode_rotate_reg.sv
// DW-bit load/rotate/shift register with single-step (en) and autonomous
// burst (start/busy/done) operation.
module multi_mode_rotate_reg
  import multi_mode_rotate_reg_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3,
  parameter int unsigned CW = 4
) (
  input logic                     clk,
  input logic                     async_rst_n,
  multi_mode_rotate_reg_if.slave  bus
);

  state_e        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [2:0]    mode_q, mode_d;
  logic [AW-1:0] amt_q, amt_d;
  logic          done_q, done_d;

  logic [2:0]    step_mode;
  logic [AW-1:0] step_amt;
  logic [DW-1:0] step_res;

  // A running burst uses the operation latched at start, not the live inputs.
  assign step_mode = (state_q == ST_RUN) ? mode_q : bus.mode;
  assign step_amt  = (state_q == ST_RUN) ? amt_q  : bus.amt;

  rotate_shift_unit #(
    .DW (DW),
    .AW (AW)
  ) u_rotate_shift_unit (
    .q      (q_q),
    .mode   (step_mode),
    .amt    (step_amt),
    .ser_in (bus.ser_in),
    .res    (step_res)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      amt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          q_d = bus.data;
        end else if (bus.start) begin
          if (bus.cnt != '0) begin
            mode_d  = bus.mode;
            amt_d   = bus.amt;
            rem_d   = bus.cnt;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.en) begin
          q_d = step_res;
        end
      end
      ST_RUN: begin
        if (bus.load) begin
          // Abort: take the new data, drop the burst, no completion pulse.
          q_d     = bus.data;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else begin
          q_d   = step_res;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.q       = q_q;
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = done_q;
  assign bus.ser_out = ser_from_lsb(bus.mode) ? q_q[0] : q_q[DW-1];

endmodule

// File: tb/tb_multi_mode_rotate_reg.sv
// Self-checking bench: directed cases with literal expectations plus random
// traffic, all compared every cycle against a behavioural model.
module tb_multi_mode_rotate_reg;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Behavioural model state
  int m_q, m_rem, m_mode, m_amt;
  bit m_busy, m_done;

  multi_mode_rotate_reg_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  multi_mode_rotate_reg #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk         (clk),
    .async_rst_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One operation expressed as plain arithmetic on an 8-bit value.
  function automatic int step(input int v, input int mode, input int amt, input int sin);
    int s;
    int fill;
    s = amt % DW;
    case (mode)
      1: return ((v >> s) | (v << (DW - s))) & 'hFF;
      2: return ((v << s) | (v >> (DW - s))) & 'hFF;
      3, 5: begin
        fill = (mode == 5) ? ((v >> 7) & 1) : sin;
        if (amt >= DW) return fill ? 'hFF : 0;
        return ((v >> amt) | (fill ? (('hFF << (DW - amt)) & 'hFF) : 0)) & 'hFF;
      end
      4: begin
        if (amt >= DW) return sin ? 'hFF : 0;
        return ((v << amt) | (sin ? ((1 << amt) - 1) : 0)) & 'hFF;
      end
      default: return v;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = 0; m_rem = 0; m_mode = 0; m_amt = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.load) m_q = int'(bus.data);
        else if (bus.start && bus.cnt != 0) begin
          m_mode = int'(bus.mode); m_amt = int'(bus.amt); m_rem = int'(bus.cnt); m_busy = 1;
        end else if (bus.start) m_done = 1;
        else if (bus.en) m_q = step(m_q, int'(bus.mode), int'(bus.amt), int'(bus.ser_in));
      end else if (bus.load) begin
        m_q = int'(bus.data); m_busy = 0;
      end else begin
        m_q = step(m_q, m_mode, m_amt, int'(bus.ser_in));
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    int m;
    #1;
    m = int'(bus.mode);
    check("cyc_q", int'(bus.q), m_q);
    check("cyc_busy", int'(bus.busy), int'(m_busy));
    check("cyc_done", int'(bus.done), int'(m_done));
    check("cyc_ser_out", int'(bus.ser_out),
          (m == 1 || m == 3 || m == 5) ? (m_q & 1) : ((m_q >> 7) & 1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.load = 0; bus.data = '0; bus.en = 0; bus.mode = '0; bus.amt = '0;
    bus.ser_in = 0; bus.start = 0; bus.cnt = '0;
  endtask

  task automatic do_load(input logic [7:0] v);
    idle_inputs();
    bus.load = 1; bus.data = v;
    tick();
    bus.load = 0;
  endtask

  // Literal expectation on q, also pinning the model to the same value.
  task automatic lit(input string name, input int exp);
    check({name, "_q"}, int'(bus.q), exp);
    check({name, "_model"}, m_q, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 0;
    idle_inputs();
    tick();
    lit("reset", 'h00);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    rst_n = 1;

    // Asynchronous reset lands between edges
    do_load(8'hB4);
    lit("pre_reset", 'hB4);
    #1 rst_n = 0;
    #1;
    check("async_q", int'(bus.q), 0);
    check("async_busy", int'(bus.busy), 0);
    #2 rst_n = 1;

    // Single steps
    do_load(8'hB4);
    bus.en = 1; bus.mode = 3'd1; bus.amt = 3'd1; tick(); lit("ror1", 'h5A);
    bus.mode = 3'd2; bus.amt = 3'd3; tick(); lit("rol3", 'hD2);
    bus.mode = 3'd0; tick(); lit("hold", 'hD2);
    bus.mode = 3'd1; bus.amt = 3'd0; tick(); lit("ror0", 'hD2);

    // Shifts and serial output
    do_load(8'h81);
    bus.en = 1; bus.mode = 3'd5; bus.amt = 3'd2; tick(); lit("sar2", 'hE0);
    check("ser_sar", int'(bus.ser_out), 0);
    do_load(8'h0F);
    bus.en = 1; bus.mode = 3'd3; bus.amt = 3'd4; bus.ser_in = 1; tick(); lit("shr4", 'hF0);
    check("ser_shr", int'(bus.ser_out), 0);
    do_load(8'h0F);
    bus.en = 1; bus.mode = 3'd4; bus.amt = 3'd7; bus.ser_in = 0; tick(); lit("shl7", 'h80);
    check("ser_shl", int'(bus.ser_out), 1);

    // Burst of 4 with live-input noise during RUN
    do_load(8'h01);
    bus.start = 1; bus.cnt = 4'd4; bus.mode = 3'd1; bus.amt = 3'd2; tick();
    lit("burst_e0", 'h01);
    check("burst_e0_busy", int'(bus.busy), 1);
    bus.mode = 3'd2; bus.amt = 3'd5; bus.en = 1; bus.cnt = 4'd3;
    tick(); lit("burst_e1", 'h40);
    tick(); lit("burst_e2", 'h10);
    check("burst_e2_busy", int'(bus.busy), 1);
    bus.start = 0;
    tick(); lit("burst_e3", 'h04);
    tick(); lit("burst_e4", 'h01);
    check("burst_end_busy", int'(bus.busy), 0);
    check("burst_end_done", int'(bus.done), 1);
    idle_inputs();
    tick();
    check("burst_done_clr", int'(bus.done), 0);

    // Abort on third RUN cycle
    do_load(8'h01);
    bus.start = 1; bus.cnt = 4'd8; bus.mode = 3'd1; bus.amt = 3'd1; tick();
    bus.start = 0;
    tick(); tick();
    bus.load = 1; bus.data = 8'h3C; tick();
    lit("abort", 'h3C);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    bus.load = 0;
    tick();
    check("abort_done_later", int'(bus.done), 0);

    // Zero-count start, then load beats start
    bus.start = 1; bus.cnt = 4'd0; tick();
    lit("zero_cnt", 'h3C);
    check("zero_busy", int'(bus.busy), 0);
    check("zero_done", int'(bus.done), 1);
    bus.start = 0; tick();
    check("zero_done_clr", int'(bus.done), 0);
    bus.load = 1; bus.data = 8'hA5; bus.start = 1; bus.cnt = 4'd5; tick();
    lit("load_wins", 'hA5);
    check("load_wins_busy", int'(bus.busy), 0);
    idle_inputs();
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.load   = ($urandom_range(0, 15) == 0);
      bus.data   = 8'($urandom);
      bus.en     = 1'($urandom);
      bus.mode   = 3'($urandom);
      bus.amt    = 3'($urandom);
      bus.ser_in = 1'($urandom);
      bus.start  = ($urandom_range(0, 7) == 0);
      bus.cnt    = 4'($urandom_range(0, 6));
      tick();
      if (i % 400 == 399) begin
        #1 rst_n = 0;
        #3 rst_n = 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
